alu_sequencer: RTL

- Sequences the 8-bit ALU for one requested operation at a time.
- Decodes a 4-bit op into one-hot ALU controls, cin and decEn, and pulses dbwa for pass-through loads.
- Holds the C/Z/V/N/D status bits, samples the ALU status outputs at the end of execution, then drives the ALU result onto adl or sb.
- Sits between the instruction decoder (requester) and the ALU.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_op_decode.sv | 57 +++++
 rtl/alu_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: op codes, FSM states, flag indices
// and the decoded control bundle handed from the decoder to the sequencer.
package alu_pkg;

    localparam logic [3:0] OP_ADC  = 4'd0;
    localparam logic [3:0] OP_SBC  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_EOR  = 4'd3;
    localparam logic [3:0] OP_ORA  = 4'd4;
    localparam logic [3:0] OP_LSR  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_ASL  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;

    localparam int FLAG_N = 4;
    localparam int FLAG_V = 3;
    localparam int FLAG_D = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // Flag-update masks in {N,V,D,Z,C} order; D is never in any mask.
    localparam logic [4:0] MASK_ARITH     = 5'b11011;
    localparam logic [4:0] MASK_ARITH_DEC = 5'b10011;
    localparam logic [4:0] MASK_LOGIC     = 5'b10010;
    localparam logic [4:0] MASK_SHIFT     = 5'b10011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRIVE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic       sums;
        logic       subs;
        logic       ands;
        logic       eors;
        logic       ors;
        logic       shftr;
        logic       shftcr;
        logic       dec_en;
        logic       cin;
        logic [4:0] upd_mask;
    } ctl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of an ALU op plus current C/D into one-hot ALU
// controls, carry-in, decimal enable and the set of flags the op may update.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic       c,
    input  logic       d,
    output ctl_t       ctl
);

    always_comb begin
        ctl = '0;
        case (op)
            OP_ADC: begin
                ctl.sums     = 1'b1;
                ctl.cin      = c;
                ctl.dec_en   = d;
                ctl.upd_mask = d ? MASK_ARITH_DEC : MASK_ARITH;
            end
            OP_SBC: begin
                ctl.subs     = 1'b1;
                ctl.cin      = c;
                ctl.dec_en   = d;
                ctl.upd_mask = d ? MASK_ARITH_DEC : MASK_ARITH;
            end
            OP_AND: begin
                ctl.ands     = 1'b1;
                ctl.upd_mask = MASK_LOGIC;
            end
            OP_EOR: begin
                ctl.eors     = 1'b1;
                ctl.upd_mask = MASK_LOGIC;
            end
            OP_ORA: begin
                ctl.ors      = 1'b1;
                ctl.upd_mask = MASK_LOGIC;
            end
            OP_LSR: begin
                ctl.shftr    = 1'b1;
                ctl.upd_mask = MASK_SHIFT;
            end
            OP_ROR: begin
                ctl.shftcr   = 1'b1;
                ctl.cin      = c;
                ctl.upd_mask = MASK_SHIFT;
            end
            // ASL is A+A with no carry in; the requester presents A on both inputs.
            OP_ASL: begin
                ctl.sums     = 1'b1;
                ctl.upd_mask = MASK_SHIFT;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Runs one ALU operation per request: EXEC or LOAD, DRIVE for DRIVE_CYCLES,
// then a DONE pulse. Owns the N/V/D/Z/C status register.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DRIVE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [3:0] op,
    input  logic       dest,
    input  logic [7:0] dbin,
    input  logic       cout,
    input  logic       zero,
    input  logic       overflow,
    input  logic       neg,
    input  logic       flag_we,
    input  logic [4:0] flag_wdata,
    output logic       sums,
    output logic       subs,
    output logic       ands,
    output logic       eors,
    output logic       ors,
    output logic       shftr,
    output logic       shftcr,
    output logic       decEn,
    output logic       cin,
    output logic       dbwa,
    output logic       adloa,
    output logic       sboa,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] flags,
    output state_e     dbg_state
);

    // Handshake: req is sampled only in IDLE; the requester waits for the
    // one-cycle done pulse (with err for illegal ops) before issuing again.

    localparam logic [1:0] DRV_LOAD = 2'(DRIVE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] op_q, op_d;
    logic       dest_q, dest_d;
    logic       err_q, err_d;
    logic [4:0] flags_q, flags_d;
    ctl_t       dec;
    logic [4:0] alu_status;

    alu_op_decode u_dec (
        .op  (op_q),
        .c   (flags_q[FLAG_C]),
        .d   (flags_q[FLAG_D]),
        .ctl (dec)
    );

    assign alu_status = {neg, overflow, 1'b0, zero, cout};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        dest_d  = dest_q;
        err_d   = err_q;
        flags_d = flags_q;
        sums    = 1'b0;
        subs    = 1'b0;
        ands    = 1'b0;
        eors    = 1'b0;
        ors     = 1'b0;
        shftr   = 1'b0;
        shftcr  = 1'b0;
        decEn   = 1'b0;
        cin     = 1'b0;
        dbwa    = 1'b0;
        adloa   = 1'b0;
        sboa    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flag_we) flags_d = flag_wdata;
                if (req) begin
                    if (op <= OP_ASL) begin
                        op_d    = op;
                        dest_d  = dest;
                        err_d   = 1'b0;
                        state_d = ST_EXEC;
                    end else if (op == OP_PASS) begin
                        op_d    = op;
                        dest_d  = dest;
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                busy    = 1'b1;
                sums    = dec.sums;
                subs    = dec.subs;
                ands    = dec.ands;
                eors    = dec.eors;
                ors     = dec.ors;
                shftr   = dec.shftr;
                shftcr  = dec.shftcr;
                decEn   = dec.dec_en;
                cin     = dec.cin;
                // ALU status is stable after the mid-cycle negedge latch.
                flags_d = (flags_q & ~dec.upd_mask) | (alu_status & dec.upd_mask);
                cnt_d   = DRV_LOAD;
                state_d = ST_DRIVE;
            end
            ST_LOAD: begin
                busy            = 1'b1;
                dbwa            = 1'b1;
                flags_d[FLAG_Z] = (dbin == 8'h00);
                flags_d[FLAG_N] = dbin[7];
                cnt_d           = DRV_LOAD;
                state_d         = ST_DRIVE;
            end
            ST_DRIVE: begin
                busy  = 1'b1;
                adloa = ~dest_q;
                sboa  = dest_q;
                if (cnt_q == 2'd0) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 2'd1;
            end
            ST_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            op_q    <= 4'd0;
            dest_q  <= 1'b0;
            err_q   <= 1'b0;
            flags_q <= 5'b00000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            err_q   <= err_d;
            flags_q <= flags_d;
        end
    end

    assign flags     = flags_q;
    assign dbg_state = state_q;

endmodule
